squid_syn_acc: RTL and testbench
================================

Name: squid_syn_acc

Overview:
Serial syndrome accumulator for the SQUID decoder over GF(16), primitive polynomial x^4+x+1, alpha=2. It consumes one 4-bit symbol per beat and computes the syndrome pair S0 = XOR of all sym_i and S1 = XOR of sym_i*alpha^(N-1-i). The pair is presented on a valid/ready output. The GF divider directly downstream forms S1/S0 = alpha^loc, which locates a single-symbol error.

Parameters:
NSYM, 15, symbols per codeword (2..15); i = arrival index 0..NSYM-1.
SYM_W, 4, symbol width; fixed at 4 and checked by an elaboration assertion.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  input symbol valid.
in_ready  out  1  block can accept a symbol.
in_sym  in  SYM_W  codeword symbol.
in_last  in  1  final symbol of the codeword.
syn_valid  out  1  syndrome pair valid.
syn_ready  in  1  downstream accepts the pair.
s0  out  SYM_W  syndrome S0.
s1  out  SYM_W  syndrome S1.
err_nz  out  1  (s0!=0)||(s1!=0); qualified by syn_valid.
len_err  out  1  codeword length differed from NSYM; qualified by syn_valid.

Behaviour:
- Reset values: state=ACC, acc0=0, acc1=0, cnt=0, syn_valid=0, s0=0, s1=0, err_nz=0, len_err=0. in_ready=1 is derived from state.
- A beat is accepted when in_valid && in_ready.
- States:
  - ACC: in_ready=1, syn_valid=0.
  - HOLD: in_ready=0, syn_valid=1; outputs are registered and stable.
- Each accepted beat in ACC:
  - acc0 <= acc0 ^ in_sym
  - acc1 <= mul_alpha(acc1) ^ in_sym (Horner form)
  - cnt <= cnt+1
- mul_alpha(v) = {v[2:0],1'b0} ^ (v[3] ? 4'b0011 : 4'b0000).
- End of frame: an accepted beat with in_last=1, or the beat where cnt==NSYM-1 (forced end).
- On the end-of-frame edge:
  - s0/s1 <= the updated accumulator values, i.e. they include the final symbol.
  - err_nz is computed from the new s0/s1.
  - len_err <= (in_last && cnt!=NSYM-1) || (!in_last && cnt==NSYM-1).
  - acc0, acc1, cnt <= 0; state <= HOLD.
- Latency: syn_valid rises in the cycle after the last beat is accepted.
- HOLD: when syn_ready=1, syn_valid<=0 and state<=ACC on that edge; in_ready returns high the next cycle.
- While syn_ready=0 in HOLD: s0, s1, err_nz, len_err hold unchanged, and no input is consumed.
- Throughput: one codeword per NSYM+1 cycles at best, with one bubble per frame.
- Forced end without in_last: the next accepted beats start a new frame. The upstream frame boundary is resynchronised only by that forced cut; no extra state is kept.
- in_valid=0 beats in ACC leave the accumulators unchanged; gaps are allowed mid-frame.
- Reset asserted at any time, including mid-frame or in HOLD: all state returns to reset values on that edge, and the partial frame is discarded.
- Once in HOLD, syn_ready is sampled only while syn_valid=1, and syn_valid never drops without a handshake.

Decomposition:
- Shared package squid_gf_pkg:
  - SYM_W=4, GF_POLY=5'b10011, GF_ALPHA=4'd2
  - typedef gf_sym_t = logic [3:0]
  - function gf_mul_alpha
  - enum syn_state_e {ACC, HOLD}
- No sub-module. The constant multiply is a package function; the general multiplier is not instantiated here.

Test Plan:
- All-zero 15-symbol frame, syn_ready=1 -> s0=0, s1=0, err_nz=0, len_err=0; syn_valid high for exactly 1 cycle, one cycle after the last beat.
- Symbol 0x5 at i=0, others 0 -> s0=0x5, s1=0xB (=5*alpha^14); downstream S1/S0=0x9=alpha^14; err_nz=1.
- Symbol 0x3 at i=14, others 0 -> s0=0x3, s1=0x3, err_nz=1.
- Frame as above with syn_ready held low 3 cycles -> s0/s1 stable, in_ready=0 throughout, no input consumed; on the handshake edge syn_valid=0, and in_ready=1 the following cycle.
- in_last on the 5th beat -> len_err=1, s0/s1 computed over 5 symbols. Separately, 15 beats with in_last never set -> forced end after beat 15, len_err=1.
- rst pulsed after 7 beats of a frame, then a clean all-zero frame -> s0=0, s1=0, len_err=0, showing no residue from the aborted frame.

Source files
------------

// File: rtl/squid_gf_pkg.sv
// Shared GF(16) definitions for the SQUID decoder: field constants, symbol type,
// the constant multiply by alpha, and the syndrome accumulator state encoding.
package squid_gf_pkg;

  localparam int unsigned SYM_W    = 4;
  localparam logic [4:0]  GF_POLY  = 5'b10011;
  localparam logic [3:0]  GF_ALPHA = 4'd2;

  typedef logic [3:0] gf_sym_t;

  typedef enum logic [0:0] {
    ACC,
    HOLD
  } syn_state_e;

  // Multiply by x, folding x^4 back in via the primitive polynomial.
  function automatic gf_sym_t gf_mul_alpha(input gf_sym_t v);
    return {v[2:0], 1'b0} ^ (v[3] ? GF_POLY[3:0] : 4'b0000);
  endfunction

endpackage

// File: rtl/squid_syn_acc.sv
// Serial GF(16) syndrome accumulator: S0 = XOR of symbols, S1 = Horner sum with alpha,
// presented on a valid/ready port once per codeword.
module squid_syn_acc
  import squid_gf_pkg::*;
#(
  parameter int unsigned NSYM  = 15,
  parameter int unsigned SYM_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_sym,
  input  logic             in_last,
  output logic             syn_valid,
  input  logic             syn_ready,
  output logic [SYM_W-1:0] s0,
  output logic [SYM_W-1:0] s1,
  output logic             err_nz,
  output logic             len_err
);

  localparam int unsigned CNT_W = $clog2(NSYM);

  if (SYM_W != 4) begin : g_bad_sym_w
    $error("squid_syn_acc: SYM_W must be 4");
  end
  if (NSYM < 2 || NSYM > 15) begin : g_bad_nsym
    $error("squid_syn_acc: NSYM must be in 2..15");
  end

  syn_state_e       state;
  gf_sym_t          acc0;
  gf_sym_t          acc1;
  logic [CNT_W-1:0] cnt;

  logic    beat;
  logic    cnt_end;
  logic    eof;
  gf_sym_t acc0_nxt;
  gf_sym_t acc1_nxt;

  always_comb begin
    in_ready = (state == ACC);
    beat     = in_valid && in_ready;
    cnt_end  = (cnt == CNT_W'(NSYM - 1));
    eof      = beat && (in_last || cnt_end);
    acc0_nxt = acc0 ^ in_sym;
    acc1_nxt = gf_mul_alpha(acc1) ^ in_sym;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      acc0      <= '0;
      acc1      <= '0;
      cnt       <= '0;
      syn_valid <= 1'b0;
      s0        <= '0;
      s1        <= '0;
      err_nz    <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (eof) begin
            // Results include the final symbol; accumulators clear for the next frame.
            s0        <= acc0_nxt;
            s1        <= acc1_nxt;
            err_nz    <= (acc0_nxt != '0) || (acc1_nxt != '0);
            len_err   <= (in_last && !cnt_end) || (!in_last && cnt_end);
            acc0      <= '0;
            acc1      <= '0;
            cnt       <= '0;
            syn_valid <= 1'b1;
            state     <= HOLD;
          end else if (beat) begin
            acc0 <= acc0_nxt;
            acc1 <= acc1_nxt;
            cnt  <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (syn_ready) begin
            syn_valid <= 1'b0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_squid_syn_acc.sv
// Directed, table-driven bench for squid_syn_acc with hand-computed GF(16) syndromes.
module tb_squid_syn_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_sym;
  logic       in_last;
  logic       syn_valid;
  logic       syn_ready;
  logic [3:0] s0;
  logic [3:0] s1;
  logic       err_nz;
  logic       len_err;

  int n_tests = 0;
  int n_fail  = 0;

  squid_syn_acc #(.NSYM(15), .SYM_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sym    (in_sym),
    .in_last   (in_last),
    .syn_valid (syn_valid),
    .syn_ready (syn_ready),
    .s0        (s0),
    .s1        (s1),
    .err_nz    (err_nz),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [59:0] syms;     // symbol i at bits [4i+3:4i]
    int          len;
    int          last_idx; // beat carrying in_last, -1 for none
    bit          gap;      // idle cycle after every beat
    logic [3:0]  e_s0;
    logic [3:0]  e_s1;
    logic        e_err;
    logic        e_len;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one frame; leaves syn_ready as the caller set it. Returns at the negedge
  // right after the final beat was taken.
  task automatic drive_frame(input vec_t v);
    for (int i = 0; i < v.len; i++) begin
      @(negedge clk);
      check({v.name, " in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_sym   = v.syms[i*4 +: 4];
      in_last  = (i == v.last_idx);
      if (v.gap && i != v.len - 1) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_sym   = 4'hF;
        in_last  = 1'b1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_sym   = 4'h0;
  endtask

  task automatic check_result(input vec_t v);
    check({v.name, " syn_valid"}, 32'(syn_valid), 32'd1);
    check({v.name, " s0"}, 32'(s0), 32'(v.e_s0));
    check({v.name, " s1"}, 32'(s1), 32'(v.e_s1));
    check({v.name, " err_nz"}, 32'(err_nz), 32'(v.e_err));
    check({v.name, " len_err"}, 32'(len_err), 32'(v.e_len));
  endtask

  task automatic run_vec(input vec_t v);
    syn_ready = 1'b1;
    drive_frame(v);
    check_result(v);
    check({v.name, " in_ready during hold"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    check({v.name, " syn_valid one cycle"}, 32'(syn_valid), 32'd0);
    check({v.name, " in_ready after hs"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{"zeros",   60'h0,                 15, 14, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    vecs[1] = '{"sym5_i0", 60'h5,                 15, 14, 1'b0, 4'h5, 4'hB, 1'b1, 1'b0};
    vecs[2] = '{"sym3_i14", {4'h3, 56'h0},        15, 14, 1'b0, 4'h3, 4'h3, 1'b1, 1'b0};
    vecs[3] = '{"short5",  60'h54321,             5,  4,  1'b0, 4'h1, 4'h1, 1'b1, 1'b1};
    vecs[4] = '{"forced",  60'h111111111111111,   15, -1, 1'b0, 4'h1, 4'h0, 1'b1, 1'b1};
    vecs[5] = '{"gapped",  60'h5,                 15, 14, 1'b1, 4'h5, 4'hB, 1'b1, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sym    = 4'h0;
    in_last   = 1'b0;
    syn_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset syn_valid", 32'(syn_valid), 32'd0);
    check("reset s0", 32'(s0), 32'd0);
    check("reset s1", 32'(s1), 32'd0);
    check("reset err_nz", 32'(err_nz), 32'd0);
    check("reset len_err", 32'(len_err), 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Backpressure: hold 3 cycles while upstream keeps offering junk.
    syn_ready = 1'b0;
    drive_frame(vecs[1]);
    check_result(vecs[1]);
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_sym   = 4'hA;
      in_last  = 1'b1;
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp syn_valid", 32'(syn_valid), 32'd1);
      check("bp s0", 32'(s0), 32'h5);
      check("bp s1", 32'(s1), 32'hB);
      check("bp err_nz", 32'(err_nz), 32'd1);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    syn_ready = 1'b1;
    @(negedge clk);
    check("bp hs syn_valid", 32'(syn_valid), 32'd0);
    check("bp hs in_ready", 32'(in_ready), 32'd1);
    // A junk beat leaking in would leave a residue in this clean frame.
    run_vec(vecs[0]);

    // Reset mid-frame after 7 beats of 0xF.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_sym   = 4'hF;
      in_last  = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst syn_valid", 32'(syn_valid), 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd1);
    run_vec(vecs[0]);

    // Reset while holding a result.
    syn_ready = 1'b0;
    drive_frame(vecs[2]);
    check_result(vecs[2]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("holdrst syn_valid", 32'(syn_valid), 32'd0);
    check("holdrst s0", 32'(s0), 32'd0);
    check("holdrst in_ready", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
